// File: rtl/prog_loader.sv
// Boot loader for rv32i_sc: writes a header-framed word stream into IMEM, then DMEM, then releases the core.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum word (sum of payload words) before DONE.
module prog_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned I_DEPTH    = 256,
    parameter int unsigned D_DEPTH    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  pc_stall,
    output logic                  d_bram_init_done,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD_I,
        LOAD_D,
        DONE,
        ERR,
        CHECK
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FINAL_ST = CHECK;
`else
    localparam state_t FINAL_ST = DONE;
`endif

    state_t                state_q, state_d;
    logic                  active_d;
    logic                  in_ready_q, busy_q, error_q, init_done_q, pc_stall_q;
    logic [CNT_W-1:0]      i_cnt_q, d_cnt_q, idx_q;
    logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
    logic [DATA_WIDTH-1:0] i_dat_q, d_dat_q;
    logic                  i_enb_q, d_enb_q;

    logic                  accept_c, last_i_c, last_d_c, hdr_bad_c, done_hold_c;
    logic [CNT_W-1:0]      hdr_i_c, hdr_d_c;
    logic [ADDR_WIDTH-1:0] addr_c;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  sum_ok_c;
    assign sum_ok_c = (in_data == sum_q);
`endif

    assign accept_c    = in_valid && in_ready_q;
    assign hdr_i_c     = in_data[15:0];
    assign hdr_d_c     = in_data[31:16];
    assign hdr_bad_c   = (32'(hdr_i_c) > I_DEPTH) || (32'(hdr_d_c) > D_DEPTH);
    assign last_i_c    = (idx_q == i_cnt_q - CNT_W'(1));
    assign last_d_c    = (idx_q == d_cnt_q - CNT_W'(1));
    assign addr_c      = ADDR_WIDTH'({idx_q, 2'b00});
    // Core gets the DMEM port only once DONE has lasted a full cycle (after the final write pulse).
    assign done_hold_c = (state_q == DONE) && (state_d == DONE);
    assign active_d    = state_d inside {HEADER, LOAD_I, LOAD_D, CHECK};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = HEADER;
            end
            HEADER: begin
                if (accept_c) begin
                    if (hdr_bad_c)               state_d = ERR;
                    else if (hdr_i_c != '0)      state_d = LOAD_I;
                    else if (hdr_d_c != '0)      state_d = LOAD_D;
                    else                         state_d = FINAL_ST;
                end
            end
            LOAD_I: begin
                if (accept_c && last_i_c) state_d = (d_cnt_q != '0) ? LOAD_D : FINAL_ST;
            end
            LOAD_D: begin
                if (accept_c && last_d_c) state_d = FINAL_ST;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept_c) state_d = sum_ok_c ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            init_done_q <= 1'b0;
            pc_stall_q  <= 1'b1;
            i_cnt_q     <= '0;
            d_cnt_q     <= '0;
            idx_q       <= '0;
            i_addr_q    <= '0;
            i_dat_q     <= '0;
            i_enb_q     <= 1'b0;
            d_addr_q    <= '0;
            d_dat_q     <= '0;
            d_enb_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= active_d;
            busy_q      <= active_d;
            error_q     <= (state_d == ERR);
            init_done_q <= done_hold_c;
            pc_stall_q  <= !done_hold_c;
            i_enb_q     <= 1'b0;
            d_enb_q     <= 1'b0;
            case (state_q)
                HEADER: begin
                    if (accept_c) begin
                        i_cnt_q <= hdr_i_c;
                        d_cnt_q <= hdr_d_c;
                        idx_q   <= '0;
                    end
                end
                LOAD_I: begin
                    if (accept_c) begin
                        i_enb_q  <= 1'b1;
                        i_addr_q <= addr_c;
                        i_dat_q  <= in_data;
                        idx_q    <= last_i_c ? '0 : idx_q + CNT_W'(1);
                    end
                end
                LOAD_D: begin
                    if (accept_c) begin
                        d_enb_q  <= 1'b1;
                        d_addr_q <= addr_c;
                        d_dat_q  <= in_data;
                        idx_q    <= last_d_c ? '0 : idx_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
`ifdef PROG_LOADER_CHECKSUM_EN
            if (start && (state_q inside {IDLE, DONE, ERR}))
                sum_q <= '0;
            else if (accept_c && (state_q inside {LOAD_I, LOAD_D}))
                sum_q <= sum_q + in_data;
`endif
        end
    end

    assign in_ready         = in_ready_q;
    assign busy             = busy_q;
    assign error            = error_q;
    assign pc_stall         = pc_stall_q;
    assign d_bram_init_done = init_done_q;
    assign i_w_addr         = i_addr_q;
    assign i_w_dat          = i_dat_q;
    assign i_w_enb          = i_enb_q;
    assign d_w_addr         = d_addr_q;
    assign d_w_dat          = d_dat_q;
    assign d_w_enb          = d_enb_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time loader for the rv32i_sc single-cycle core.
- Accepts a valid/ready word stream and writes the program into instruction BRAM and the data image into data BRAM through their write ports.
- Holds the PC stalled while loading. Hands data-BRAM write-port ownership to the core when done.
- Parametrised in word width, address width and per-memory depth; validates header counts against depth.

Parameters:
- DATA_WIDTH, 32, stream word and BRAM data width.
- ADDR_WIDTH, 10, BRAM byte-address width.
- I_DEPTH, 256, instruction BRAM capacity in words.
- D_DEPTH, 256, data BRAM capacity in words.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse; begins a load session
- in_valid  in  1  stream word valid
- in_data  in  DATA_WIDTH  stream word
- in_ready  out  1  loader accepts word this cycle
- i_w_addr  out  ADDR_WIDTH  IMEM byte write address
- i_w_dat  out  DATA_WIDTH  IMEM write data
- i_w_enb  out  1  IMEM write enable
- d_w_addr  out  ADDR_WIDTH  DMEM byte write address
- d_w_dat  out  DATA_WIDTH  DMEM write data
- d_w_enb  out  1  DMEM write enable
- pc_stall  out  1  stall to PC
- d_bram_init_done  out  1  DMEM write-port mux select (1 = core owns port)
- busy  out  1  session in progress
- error  out  1  sticky load error

Behaviour:
- Reset (async, immediate): state IDLE; pc_stall=1; every other output 0, including addresses and data.
- Stream format:
  - Word 0 is the header: instr_count = in_data[15:0], data_count = in_data[31:16].
  - Then instr_count IMEM words, then data_count DMEM words.
- States: IDLE, HEADER, LOAD_I, LOAD_D, DONE, ERR (plus CHECK, see Optional Feature).
- IDLE/DONE/ERR:
  - start -> HEADER; clears error and d_bram_init_done; sets pc_stall=1.
  - start in any other state is ignored.
- in_ready = 1 only in HEADER, LOAD_I, LOAD_D (and CHECK). A word is accepted when in_valid && in_ready.
- HEADER on accept:
  - instr_count > I_DEPTH or data_count > D_DEPTH -> ERR.
  - Otherwise -> LOAD_I if instr_count != 0; else LOAD_D if data_count != 0; else DONE.
- LOAD_I / LOAD_D, per accepted word k (0-based):
  - The next cycle drives x_w_addr = k*4 (low ADDR_WIDTH bits), x_w_dat = word, x_w_enb = 1 for exactly one cycle.
  - Registered outputs, 1-cycle latency.
  - Back-to-back accepts produce back-to-back enables.
  - After the last word: LOAD_I -> LOAD_D (or DONE if data_count = 0); LOAD_D -> DONE.
- DONE:
  - Entered the cycle after the last accept; the final write pulse coincides with DONE entry.
  - d_bram_init_done=1 and pc_stall=0 from the cycle after the final write enable, so a core write can never collide with the loader.
- ERR: error=1, pc_stall=1, d_bram_init_done=0. No further writes.
- busy = 1 in HEADER, LOAD_I, LOAD_D, CHECK.
- in_valid low mid-load: state holds, no enables, counters hold.
- Unused address bits above ADDR_WIDTH are truncated. Depth checks use word counts, never addresses.
- Reset mid-load: everything aborts; a partially written BRAM is not cleared; pc_stall stays 1.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running sum mod 2^DATA_WIDTH of all payload words (header excluded).
  - After the last payload word, state CHECK accepts one extra word.
  - Equal to the sum -> DONE; mismatch -> ERR.
  - Zero-payload sessions still expect a checksum word of 0.
- Undefined: no CHECK state and no sum register; the last payload word goes straight to DONE.

Test Plan:
- Header 0x0004_000E, 14 instr + 4 data words, in_valid always high -> 14 consecutive i_w_enb pulses at addresses 0x000..0x034, then 4 d_w_enb pulses at 0x000..0x00C; d_bram_init_done=1 and pc_stall=0 one cycle after the last d_w_enb; error=0.
- Same stream with in_valid toggling every other cycle -> identical writes, spaced one idle cycle apart; no duplicate or missing enables.
- Header 0x0000_0101 (instr_count=257 > I_DEPTH) -> ERR the cycle after accept; error=1; no write enables; pc_stall=1.
- Header 0x0000_0000 -> DONE with zero writes (checksum build: only after checksum word 0x0).
- Reset asserted after 5 of 14 IMEM words -> outputs immediately return to reset values; start then restarts cleanly from address 0.
- PROG_LOADER_CHECKSUM_EN, header 0x0001_0001, words 0x10, 0x20: checksum 0x30 -> DONE; checksum 0x31 -> ERR, error=1, d_bram_init_done=0.
